// File: rtl/moore_serial_pkg.sv
// Shared definitions for the Moore-type serial adder/subtractor datapaths.
package moore_serial_pkg;

    // Width of the {borrow/carry, sum/diff} Moore state.
    localparam int unsigned STATE_W = 2;

    // State encoding {borrow, diff}: G = no borrow pending, H = borrow pending.
    typedef enum logic [STATE_W-1:0] {
        G0 = 2'b00,
        G1 = 2'b01,
        H0 = 2'b10,
        H1 = 2'b11
    } serial_state_e;

    // Next state of the serial subtractor given the current state and operand bits.
    function automatic serial_state_e sub_next_state(
        input serial_state_e cur,
        input logic          a_bit,
        input logic          b_bit
    );
        serial_state_e nxt;
        nxt = G0;
        if (cur[1] == 1'b0) begin
            case ({a_bit, b_bit})
                2'b00:   nxt = G0;
                2'b01:   nxt = H1;
                2'b10:   nxt = G1;
                default: nxt = G0;
            endcase
        end else begin
            case ({a_bit, b_bit})
                2'b00:   nxt = H1;
                2'b01:   nxt = H0;
                2'b10:   nxt = G0;
                default: nxt = H1;
            endcase
        end
        return nxt;
    endfunction

    // Serial output bit carried by a state (its LSB).
    function automatic logic state_out_bit(input serial_state_e s);
        return s[0];
    endfunction

    // Borrow/carry flag carried by a state (its MSB).
    function automatic logic state_flag_bit(input serial_state_e s);
        return s[1];
    endfunction

endpackage

// File: rtl/moore_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface moore_subtractor_if #(
    parameter int unsigned N = 4
);

    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] diff;
    logic         borrow;
    logic         busy;
    logic         done;

    // Sequencer side: issues operations, observes results.
    modport master (
        output start, A, B,
        input  diff, borrow, busy, done
    );

    // Datapath side: accepts operations, produces results.
    modport slave (
        input  start, A, B,
        output diff, borrow, busy, done
    );

endinterface

// File: rtl/moore_subtractor_shift_reg.sv
// Parallel-load, serial-in shift-right register with async active-high clear.
module shift_reg_n #(
    parameter int unsigned N = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic         sin,
    input  logic [N-1:0] pdata,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Load has priority over shifting; serial input enters at the MSB.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = pdata;
        end else if (en) begin
            q_d = {sin, q_q[N-1:1]};
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/moore_subtractor.sv
// Moore-type serial subtractor: A - B one bit per clock, LSB first, with borrow-out.
module moore_subtractor
    import moore_serial_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 4
) (
    input  logic               clock,
    input  logic               resetn,
    moore_subtractor_if.slave  bus
);

    // Busy cycles per operation: N data bits plus one borrow-flush cycle.
    localparam int unsigned OP_CYCLES = N + 1;

    serial_state_e state_q;
    serial_state_e state_d;
    serial_state_e next_c;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          busy_q;
    logic          busy_d;
    logic          done_q;
    logic          done_d;
    logic          borrow_q;
    logic          borrow_d;
    logic          accept_c;

    logic [N-1:0]  qa_q;
    logic [N-1:0]  qb_q;
    logic [N-1:0]  diff_q;

    // Only the LSBs of the operand registers feed the FSM.
    logic          unused_operand_msbs;
    assign unused_operand_msbs = ^{qa_q[N-1:1], qb_q[N-1:1]};

    // A request is taken only while idle; requests during busy are dropped.
    assign accept_c = bus.start & ~busy_q;

    // Minuend shift register: loaded on accept, drains LSB first while busy.
    shift_reg_n #(
        .N (N)
    ) u_qa (
        .clock (clock),
        .rst   (resetn),
        .load  (accept_c),
        .en    (busy_q),
        .sin   (1'b0),
        .pdata (bus.A),
        .q     (qa_q)
    );

    // Subtrahend shift register.
    shift_reg_n #(
        .N (N)
    ) u_qb (
        .clock (clock),
        .rst   (resetn),
        .load  (accept_c),
        .en    (busy_q),
        .sin   (1'b0),
        .pdata (bus.B),
        .q     (qb_q)
    );

    // Result register: cleared on accept, collects the state's diff bit at the MSB.
    shift_reg_n #(
        .N (N)
    ) u_diff (
        .clock (clock),
        .rst   (resetn),
        .load  (accept_c),
        .en    (busy_q),
        .sin   (state_out_bit(state_q)),
        .pdata ('0),
        .q     (diff_q)
    );

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        borrow_d = borrow_q;
        next_c   = sub_next_state(state_q, qa_q[0], qb_q[0]);

        if (accept_c) begin
            state_d = G0;
            count_d = CW'(OP_CYCLES);
            busy_d  = 1'b1;
        end else if (busy_q) begin
            state_d = next_c;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                // Flush cycle ran on zero bits, so next_c carries the final borrow.
                busy_d   = 1'b0;
                done_d   = 1'b1;
                borrow_d = state_flag_bit(next_c);
            end
        end
    end

    // FSM state, counter and output flags.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state_q  <= G0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: doc/moore_subtractor.md
Name: moore_subtractor

Overview:
- Moore-type FSM serial subtractor. Computes A - B one bit per clock, LSB first, and flags the borrow-out.
- It is the complementary datapath to the serial adder. It uses the same load/shift/count structure and the same two-bit {borrow,diff} Moore state encoding.
- It sits beside the adder in the serial ALU. A start/done handshake lets a sequencer issue back-to-back operations.

Parameters:
- N, 4, operand and result width in bits (N >= 2).
- CW, 4, count register width; must satisfy 2^CW > N+1.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  reset, asynchronous, active-high (asserted = 1 clears the block).
- start  in  1  request; sampled only while busy = 0.
- A  in  N  minuend; captured on the accepted start.
- B  in  N  subtrahend; captured on the accepted start.
- diff  out  N  result register, A - B mod 2^N; valid from done until the next accepted start.
- borrow  out  1  borrow-out: 1 when A < B unsigned; valid with diff.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (resetn = 1, async):
  - diff = 0, borrow = 0, busy = 0, done = 0.
  - FSM state = G0, count = 0, operand shift registers = 0.
- Moore state encoding, {borrow,diff}: G0 = 00, G1 = 01, H0 = 10, H1 = 11. The serial diff bit is the state's LSB and depends on state only.
- Next state from borrow-0 states (G0, G1), on {a,b} = {QA[0],QB[0]}:
  - 00 -> G0, 01 -> H1, 10 -> G1, 11 -> G0.
- Next state from borrow-1 states (H0, H1):
  - 00 -> H1, 01 -> H0, 10 -> G0, 11 -> H1.
- Accept: start = 1 while busy = 0, at the clock edge:
  - QA <= A, QB <= B, state <= G0, count <= N+1, busy <= 1, done <= 0.
  - diff is cleared to 0.
- Each busy cycle:
  - state <= next state.
  - QA and QB shift right with 0 filled at the MSB.
  - diff shifts right, inserting the current state's diff bit at the MSB.
  - count decrements.
- Latency:
  - The first busy shift inserts the G0 dummy bit (0); it is shifted out by the end of the operation.
  - The operation takes exactly N+1 busy cycles.
  - On the edge where count goes 1 -> 0: busy <= 0, done <= 1, borrow <= borrow bit of the next state.
  - The extra zero-bit cycle preserves the borrow (00 with borrow 1 -> H1), so borrow is correct at that edge.
- Total latency: start accepted at edge k; done is high in the cycle following edge k+N+1.
- done is high for exactly one cycle. diff and borrow then hold until the next accept.
- start while busy = 1 is ignored, with no effect on the operands or the count.
- start may be accepted in the same cycle done is high (busy is already 0) for back-to-back operation. done then drops on the next edge.
- Reset mid-operation aborts immediately to the reset values. No done pulse is produced.
- Arithmetic: diff = (A - B) mod 2^N; borrow = (A < B).

Decomposition:
- Shared package moore_serial_pkg holds:
  - the state localparams G0/G1/H0/H1, shared with the adder;
  - the 2-bit state width constant.
- One natural sub-module: shift_reg_n, a parallel-load / serial-in shift-right register with load, enable, serial input and width parameter N, plus async active-high clear.
  - Instantiate it three times: QA, QB and diff.
- The FSM and the counter stay in the top level.

Test Plan:
- N=4, A=9, B=3, one start pulse -> busy for 5 cycles; done pulse in the 6th cycle after the accept edge; diff=6, borrow=0.
- A=3, B=9 -> diff=4'hA, borrow=1. A=0, B=15 -> diff=1, borrow=1. A=15, B=15 -> diff=0, borrow=0.
- start re-asserted on every cycle of a 9-3 operation -> the result is unchanged (diff=6) and only one done pulse occurs. Then start with A=5, B=2 on the done cycle -> the next done gives diff=3 with no idle gap.
- resetn pulsed for 1 cycle during the 3rd busy cycle -> busy, done, diff and borrow read 0 asynchronously and no done pulse follows. A fresh start with 7-7 -> diff=0, borrow=0.
- N=8: A=200, B=55 -> diff=145, borrow=0 after 9 busy cycles. Then A=55, B=200 -> diff=111, borrow=1.
- Random regression, N=4 and N=8, 1000 operations -> diff == (A-B) mod 2^N and borrow == (A<B) on every done.
